// File: rtl/stage5_bsn_track.sv
// stage5_bsn_track
//   Stage-5 BSN field extractor and tracker, NUM_CH channels per beat.
//   For each channel whose mux/type controls select an N-type M-subtype
//   message, the BSN field is pulled out of the message and classified
//   against that channel's previous BSN as FIRST / ADVANCE / REPEAT / JUMP.
//   Jumps are counted per channel with a saturating counter. Results sit in a
//   single output register stage behind a valid/ready handshake.
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     input beat valid; in_ready: beat accepted this cycle
//   message      NUM_CH messages, channel i at [i*MSG_BITS +: MSG_BITS]
//   mux_ctrl     per-channel message mux control (MUX_W bits each)
//   ntype_ctrl   per-channel N type control (NT_W bits each)
//   clear_hist   per-channel history clear, acts every cycle
//   out_valid    output beat valid; out_ready: downstream accepts
//   bsn          per-channel extracted BSN, DEF_INFOR when not hit
//   bsn_hit      per-channel hit flag
//   bsn_stat     per-channel class: 00 FIRST, 01 ADVANCE, 10 REPEAT, 11 JUMP
//   jump_cnt     per-channel saturating jump counter
module stage5_bsn_track #(
  parameter int NUM_CH    = 3,
  parameter int MSG_BITS  = 256,
  parameter int BSN_BITS  = 7,
  parameter int BSN_MSB   = 23,
  parameter int MUX_W     = 2,
  parameter int NT_W      = 2,
  parameter int MUX_N_VAL = 1,
  parameter int NT_M_VAL  = 1,
  parameter int DEF_INFOR = 0,
  parameter int CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*MSG_BITS-1:0]   message,
  input  logic [NUM_CH*MUX_W-1:0]      mux_ctrl,
  input  logic [NUM_CH*NT_W-1:0]       ntype_ctrl,
  input  logic [NUM_CH-1:0]            clear_hist,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*BSN_BITS-1:0]   bsn,
  output logic [NUM_CH-1:0]            bsn_hit,
  output logic [NUM_CH*2-1:0]          bsn_stat,
  output logic [NUM_CH*CNT_W-1:0]      jump_cnt
);

  localparam logic [BSN_BITS-1:0] DEF_V    = BSN_BITS'(DEF_INFOR);
  localparam logic [MUX_W-1:0]    MUX_SEL  = MUX_W'(MUX_N_VAL);
  localparam logic [NT_W-1:0]     NT_SEL   = NT_W'(NT_M_VAL);
  localparam logic [1:0]          ST_FIRST = 2'b00;
  localparam logic [1:0]          ST_ADV   = 2'b01;
  localparam logic [1:0]          ST_REP   = 2'b10;
  localparam logic [1:0]          ST_JUMP  = 2'b11;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                       out_valid_q, out_valid_d;
  logic [NUM_CH*BSN_BITS-1:0] bsn_q, bsn_d;
  logic [NUM_CH-1:0]          hit_q, hit_d;
  logic [NUM_CH*2-1:0]        stat_q, stat_d;
  logic [NUM_CH*CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH*BSN_BITS-1:0] hist_bsn_q, hist_bsn_d;
  logic [NUM_CH-1:0]          hist_vld_q, hist_vld_d;
  logic                       accept;

  // Only the BSN field of each message is consumed.
  logic unused_msg;
  assign unused_msg = ^message;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    logic                hit_c;
    logic [BSN_BITS-1:0] new_c;
    logic [BSN_BITS-1:0] adv_c;
    logic [BSN_BITS-1:0] hist_c;
    logic [CNT_W-1:0]    cnt_c;
    logic [1:0]          st_c;
    out_valid_d = out_valid_q;
    bsn_d       = bsn_q;
    hit_d       = hit_q;
    stat_d      = stat_q;
    cnt_d       = cnt_q;
    hist_bsn_d  = hist_bsn_q;
    hist_vld_d  = hist_vld_q;
    hit_c       = 1'b0;
    new_c       = '0;
    adv_c       = '0;
    hist_c      = '0;
    cnt_c       = '0;
    st_c        = ST_FIRST;

    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;

    for (int i = 0; i < NUM_CH; i++) begin
      hit_c  = (mux_ctrl[i*MUX_W +: MUX_W] == MUX_SEL) &&
               (ntype_ctrl[i*NT_W +: NT_W] == NT_SEL);
      new_c  = message[i*MSG_BITS + BSN_MSB -: BSN_BITS];
      hist_c = hist_bsn_q[i*BSN_BITS +: BSN_BITS];
      adv_c  = hist_c + 1'b1;
      // A clear in the same cycle wipes the counter before the hit is judged.
      cnt_c  = clear_hist[i] ? '0 : cnt_q[i*CNT_W +: CNT_W];
      st_c   = ST_FIRST;

      if (accept && hit_c) begin
        if (clear_hist[i] || !hist_vld_q[i]) st_c = ST_FIRST;
        else if (new_c == hist_c)            st_c = ST_REP;
        else if (new_c == adv_c)             st_c = ST_ADV;
        else begin
          st_c  = ST_JUMP;
          cnt_c = sat_inc(cnt_c);
        end
        hist_bsn_d[i*BSN_BITS +: BSN_BITS] = new_c;
        hist_vld_d[i]                      = 1'b1;
        cnt_d[i*CNT_W +: CNT_W]            = cnt_c;
      end else if (clear_hist[i]) begin
        hist_vld_d[i]           = 1'b0;
        cnt_d[i*CNT_W +: CNT_W] = '0;
      end

      if (accept) begin
        bsn_d[i*BSN_BITS +: BSN_BITS] = hit_c ? new_c : DEF_V;
        hit_d[i]                      = hit_c;
        stat_d[i*2 +: 2]              = hit_c ? st_c : ST_FIRST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bsn_q       <= {NUM_CH{DEF_V}};
      hit_q       <= '0;
      stat_q      <= '0;
      cnt_q       <= '0;
      hist_bsn_q  <= '0;
      hist_vld_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bsn_q       <= bsn_d;
      hit_q       <= hit_d;
      stat_q      <= stat_d;
      cnt_q       <= cnt_d;
      hist_bsn_q  <= hist_bsn_d;
      hist_vld_q  <= hist_vld_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bsn       = bsn_q;
  assign bsn_hit   = hit_q;
  assign bsn_stat  = stat_q;
  assign jump_cnt  = cnt_q;

endmodule
